// File: rtl/alu_op_sequencer.sv
// Buffers ALU operation requests in a FIFO, issues them one at a time to the ALU and returns
// captured results on a valid/ready response port. ALU_SEQ_STATS_EN adds op/error counters.
module alu_op_sequencer #(
  parameter int unsigned W       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LAT     = 1,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           req_mode_i,
  input  logic [3:0]     req_cmd_i,
  input  logic [W-1:0]   req_opa_i,
  input  logic [W-1:0]   req_opb_i,
  input  logic           req_cin_i,
  output logic [1:0]     inp_valid_o,
  output logic           mode_o,
  output logic [3:0]     cmd_o,
  output logic           cin_o,
  output logic [W-1:0]   opa_o,
  output logic [W-1:0]   opb_o,
  output logic           ce_o,
  input  logic [2*W-1:0] res_i,
  input  logic           err_i,
  input  logic           oflow_i,
  input  logic           cout_i,
  input  logic           g_i,
  input  logic           l_i,
  input  logic           e_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [2*W-1:0] rsp_res_o,
  output logic [5:0]     rsp_flags_o,
  output logic [4:0]     rsp_cmd_o
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]    op_count_o,
  output logic [15:0]    err_count_o
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic         mode;
    logic [3:0]   cmd;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         cin;
  } op_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  op_t               mem_q [DEPTH];
  op_t               op_q, op_d, req_op;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [2:0]        wait_q, wait_d;
  logic              init_q;
  logic              push, pop, capture, fifo_empty, is_mul, drive;
  logic [2*W-1:0]    rsp_res_q;
  logic [5:0]        rsp_flags_q;
  logic [4:0]        rsp_cmd_q;

  assign req_op     = '{mode: req_mode_i, cmd: req_cmd_i, opa: req_opa_i, opb: req_opb_i,
                        cin: req_cin_i};
  assign fifo_empty = (count_q == '0);
  // init_q holds ready low until the first edge after reset release
  assign req_ready_o = init_q && (count_q != CntW'(DEPTH));
  assign push        = req_valid_i && req_ready_o;
  assign is_mul      = op_q.mode && ((op_q.cmd == 4'd9) || (op_q.cmd == 4'd10));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        wait_d  = is_mul ? 3'(MUL_LAT) : 3'(LAT);
        state_d = StWait;
      end
      StWait: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == 3'd1) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) op_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= req_op;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      op_q        <= '0;
      wait_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      init_q      <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      rsp_cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      init_q  <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
      if (capture) begin
        rsp_res_q   <= res_i;
        rsp_flags_q <= {err_i, oflow_i, cout_i, g_i, l_i, e_i};
        rsp_cmd_q   <= {op_q.mode, op_q.cmd};
      end
    end
  end

  // ALU pins carry the operation only while it is at the ALU; zero otherwise
  assign drive       = (state_q == StIssue) || (state_q == StWait);
  assign inp_valid_o = (state_q == StIssue) ? 2'b11 : 2'b00;
  assign ce_o        = drive;
  assign mode_o      = drive && op_q.mode;
  assign cmd_o       = drive ? op_q.cmd : '0;
  assign cin_o       = drive && op_q.cin;
  assign opa_o       = drive ? op_q.opa : '0;
  assign opb_o       = drive ? op_q.opb : '0;

  assign rsp_valid_o = (state_q == StResp);
  assign rsp_res_o   = rsp_res_q;
  assign rsp_flags_o = rsp_flags_q;
  assign rsp_cmd_o   = rsp_cmd_q;

`ifdef ALU_SEQ_STATS_EN
  logic        rsp_hs;
  logic [15:0] op_cnt_q, err_cnt_q;

  assign rsp_hs = (state_q == StResp) && rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (rsp_hs) begin
      if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
      if (rsp_flags_q[5] && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign op_count_o  = op_cnt_q;
  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: behavioural ALU with exact latency, scoreboard of expected responses,
// vector table plus backpressure, wrap-around and mid-operation reset sequences.
module tb_alu_op_sequencer;

  localparam int unsigned W       = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LAT     = 1;
  localparam int unsigned MUL_LAT = 2;

  logic           clk, rst_n;
  logic           req_valid, req_ready, req_mode, req_cin;
  logic [3:0]     req_cmd;
  logic [W-1:0]   req_opa, req_opb;
  logic [1:0]     inp_valid;
  logic           mode, cin, ce;
  logic [3:0]     cmd;
  logic [W-1:0]   opa, opb;
  logic [2*W-1:0] res;
  logic           err, oflow, cout, g, l, e;
  logic           rsp_valid, rsp_ready;
  logic [2*W-1:0] rsp_res;
  logic [5:0]     rsp_flags;
  logic [4:0]     rsp_cmd;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]    op_count, err_count;
`endif

  alu_op_sequencer #(.W(W), .DEPTH(DEPTH), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_mode_i(req_mode),
    .req_cmd_i(req_cmd), .req_opa_i(req_opa), .req_opb_i(req_opb), .req_cin_i(req_cin),
    .inp_valid_o(inp_valid), .mode_o(mode), .cmd_o(cmd), .cin_o(cin),
    .opa_o(opa), .opb_o(opb), .ce_o(ce),
    .res_i(res), .err_i(err), .oflow_i(oflow), .cout_i(cout), .g_i(g), .l_i(l), .e_i(e),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_res_o(rsp_res),
    .rsp_flags_o(rsp_flags), .rsp_cmd_o(rsp_cmd)
`ifdef ALU_SEQ_STATS_EN
    , .op_count_o(op_count), .err_count_o(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // {err,oflow,cout,g,l,e,res}
  function automatic logic [21:0] alu_f(input logic m, input logic [3:0] c,
                                        input logic [7:0] a, input logic [7:0] b,
                                        input logic ci);
    logic [15:0] r;
    logic [8:0]  s;
    logic        er, ofl, co;
    r = '0; s = '0; er = 1'b0; ofl = 1'b0; co = 1'b0;
    if (m) begin
      case (c)
        4'd0: begin s = {1'b0, a} + {1'b0, b}; r = {8'h00, s[7:0]}; co = s[8]; end
        4'd1: begin s = {1'b0, a} + {1'b0, b} + {8'h00, ci}; r = {8'h00, s[7:0]}; co = s[8]; end
        4'd2: begin r = {8'h00, a - b}; ofl = (a < b); end
        4'd9: r = {8'h00, a} * {8'h00, b};
        4'd10: r = ({8'h00, a} + 16'd1) * ({8'h00, b} + 16'd1);
        default: er = 1'b1;
      endcase
    end else begin
      case (c)
        4'd0: r = {8'h00, a & b};
        4'd1: r = {8'h00, a | b};
        4'd2: r = {8'h00, a ^ b};
        default: er = 1'b1;
      endcase
    end
    return {er, ofl, co, a > b, a < b, a == b, r};
  endfunction

  function automatic int lat_of(input logic m, input logic [3:0] c);
    return (m && (c == 4'd9 || c == 4'd10)) ? MUL_LAT : LAT;
  endfunction

  // Behavioural ALU: result visible only in the cycle exactly LAT/MUL_LAT after issue
  logic [21:0] alu_q;
  int          alu_cnt, alu_lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_cnt <= 0;
      alu_lat <= 0;
      alu_q   <= '0;
    end else if (inp_valid == 2'b11 && ce) begin
      alu_cnt <= 1;
      alu_lat <= lat_of(mode, cmd);
      alu_q   <= alu_f(mode, cmd, opa, opb, cin);
    end else if (alu_cnt != 0 && alu_cnt < 100) begin
      alu_cnt <= alu_cnt + 1;
    end
  end
  assign {err, oflow, cout, g, l, e, res} =
      (alu_cnt != 0 && alu_cnt == alu_lat) ? alu_q : {6'h2A, 16'hDEAD};

  typedef struct {
    logic [15:0] res;
    logic [5:0]  flags;
    logic [4:0]  cmd;
    logic [7:0]  a, b;
    logic        ci;
    int          lat;
  } exp_t;
  exp_t sb[$];

  // Monitor: issue contents, one-cycle INP_VALID, latency, spacing, response scoreboard
  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int  issue_cyc = 0, last_issue = 0, n_rsp = 0;
  bit  have_prev = 0, spacing_en = 0;
  logic [1:0] prev_iv = 2'b00;
  logic       prev_rv = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (inp_valid == 2'b11) begin
          chk("iv_one_cycle", {30'd0, prev_iv}, 32'd0);
          chk("issue_ce", {31'd0, ce}, 32'd1);
          if (sb.size() > 0) begin
            chk("issue_cmd", {27'd0, mode, cmd}, {27'd0, sb[0].cmd});
            chk("issue_ops", {15'd0, opa, opb, cin}, {15'd0, sb[0].a, sb[0].b, sb[0].ci});
          end
          if (spacing_en && have_prev) chk("issue_spacing", cyc - last_issue, LAT + 2);
          have_prev  = 1;
          last_issue = cyc;
          issue_cyc  = cyc;
        end
        if (rsp_valid && !prev_rv) begin
          chk("rsp_ce_low", {31'd0, ce}, 32'd0);
          if (sb.size() > 0) chk("latency", cyc - issue_cyc, sb[0].lat + 1);
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            chk("rsp_res", {16'd0, rsp_res}, {16'd0, sb[0].res});
            chk("rsp_flags", {26'd0, rsp_flags}, {26'd0, sb[0].flags});
            chk("rsp_cmd", {27'd0, rsp_cmd}, {27'd0, sb[0].cmd});
            void'(sb.pop_front());
            n_rsp++;
          end
        end
        prev_iv = inp_valid;
        prev_rv = rsp_valid;
      end else begin
        prev_iv = 2'b00;
        prev_rv = 1'b0;
      end
    end
  end

  // All stimulus tasks start and end at posedge+1
  task automatic push_raw(input logic m, input logic [3:0] c, input logic [7:0] a,
                          input logic [7:0] b, input logic ci, input logic [15:0] xr,
                          input logic [5:0] xf, input logic [4:0] xc);
    exp_t x;
    int   n = 0;
    req_mode = m; req_cmd = c; req_opa = a; req_opb = b; req_cin = ci; req_valid = 1'b1;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      chk("push_timeout", 32'd1, 32'd0);
    end else begin
      x.res = xr; x.flags = xf; x.cmd = xc; x.a = a; x.b = b; x.ci = ci; x.lat = lat_of(m, c);
      sb.push_back(x);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic push(input logic m, input logic [3:0] c, input logic [7:0] a,
                      input logic [7:0] b, input logic ci);
    logic [21:0] r;
    r = alu_f(m, c, a, b, ci);
    push_raw(m, c, a, b, ci, r[15:0], r[21:16], {m, c});
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    sb.delete();
    have_prev = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_at_release", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {inp_valid, mode, cmd, cin, ce, rsp_valid, req_ready, opa, opb},
        32'd0);
    chk({nm, "_rsp"}, {3'd0, rsp_res, rsp_flags, rsp_cmd}, 32'd0);
  endtask

  typedef struct {
    logic        m;
    logic [3:0]  c;
    logic [7:0]  a, b;
    logic        ci;
    logic [15:0] xres;
    logic [4:0]  xcmd;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 4'd0,  8'h0F, 8'h01, 1'b0, 16'h0010, 5'h10};
    vecs[1] = '{1'b1, 4'd9,  8'h03, 8'h04, 1'b0, 16'h000C, 5'h19};
    vecs[2] = '{1'b1, 4'd1,  8'hFF, 8'h01, 1'b1, 16'h0001, 5'h11};
    vecs[3] = '{1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 16'h0030, 5'h00};
    vecs[4] = '{1'b0, 4'd1,  8'hF0, 8'h0F, 1'b0, 16'h00FF, 5'h01};
    vecs[5] = '{1'b0, 4'd2,  8'hA5, 8'h0F, 1'b0, 16'h00AA, 5'h02};
    vecs[6] = '{1'b1, 4'd10, 8'h02, 8'h04, 1'b0, 16'h000F, 5'h1A};
    vecs[7] = '{1'b1, 4'd9,  8'hFF, 8'hFF, 1'b0, 16'hFE01, 5'h19};
    vecs[8] = '{1'b1, 4'd2,  8'h10, 8'h20, 1'b0, 16'h00F0, 5'h12};

    rst_n = 1'b0; req_valid = 1'b0; req_mode = 1'b0; req_cmd = '0;
    req_opa = '0; req_opb = '0; req_cin = 1'b0; rsp_ready = 1'b1;
    #12;
    chk_all_zero("reset_state");
    #9 rst_n = 1'b1;
    chk("ready_at_release", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);

    // Vector table, one at a time then back to back
    for (int i = 0; i < 9; i++) begin
      logic [21:0] r;
      r = alu_f(vecs[i].m, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].ci);
      push_raw(vecs[i].m, vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].xres,
               r[21:16], vecs[i].xcmd);
      if (i < 2) drain();
    end
    drain();

    // Backpressure: one op held in RESP, four queued, sixth stalls
    rsp_ready = 1'b0;
    push(1'b1, 4'd2, 8'h33, 8'h11, 1'b0);
    push(1'b0, 4'd0, 8'h5A, 8'hFF, 1'b0);
    push(1'b0, 4'd1, 8'h01, 8'h80, 1'b0);
    push(1'b0, 4'd2, 8'hFF, 8'h0F, 1'b0);
    push(1'b1, 4'd0, 8'h80, 8'h80, 1'b0);
    chk("full_ready", {31'd0, req_ready}, 32'd0);
    req_mode = 1'b1; req_cmd = 4'd1; req_opa = 8'h7F; req_opb = 8'h01; req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    chk("held_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("held_rsp_cmd", {27'd0, rsp_cmd}, 32'h12);
    chk("held_rsp_res", {16'd0, rsp_res}, 32'h0022);
    rsp_ready = 1'b1;
    push(1'b1, 4'd1, 8'h7F, 8'h01, 1'b0);
    drain();

    // Wrap-around stream with exact issue spacing
    have_prev  = 0;
    spacing_en = 1;
    for (int i = 0; i < 20; i++) push(1'b1, 4'd0, 8'($urandom), 8'($urandom), 1'b0);
    drain();
    spacing_en = 0;

    // Reset while an op is in WAIT with three queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1, 4'd9, 8'(i + 2), 8'(i + 7), 1'b0);
    for (int k = 0; k < 50 && !rsp_valid; k++) begin @(posedge clk); #1; end
    chk("mid_first_rsp", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 50 && inp_valid != 2'b11; k++) begin @(posedge clk); #1; end
    chk("mid_issue_seen", {30'd0, inp_valid}, 32'd3);
    @(posedge clk); #1;
    chk("mid_in_wait", {30'd0, inp_valid, ce}, 32'd1);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk_all_zero("mid_reset_outs");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    have_prev = 0;
    begin
      int nv = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (rsp_valid) nv++;
      end
      chk("no_rsp_after_reset", nv, 0);
    end
    push(1'b0, 4'd2, 8'hC3, 8'h3C, 1'b0);
    drain();

`ifdef ALU_SEQ_STATS_EN
    do_reset();
    push(1'b1, 4'd0,  8'h01, 8'h02, 1'b0);
    push(1'b1, 4'd15, 8'h01, 8'h02, 1'b0);
    push(1'b0, 4'd1,  8'h10, 8'h01, 1'b0);
    push(1'b1, 4'd9,  8'h05, 8'h05, 1'b0);
    drain();
    @(posedge clk); #1;
    chk("op_count", {16'd0, op_count}, 32'd4);
    chk("err_count", {16'd0, err_count}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
